// File: rtl/lru_bits.sv
`default_nettype none
// ============================================================================
// Module   : lru_bits
// Purpose  : 4-way true-LRU helper. Reports the victim way from a 6-bit
//            pairwise-order state and returns the state with a way made MRU.
// Revision : 1.0 - initial release
// ============================================================================
module lru_bits #(
    parameter int WAYS    = 4,
    parameter int LRUBITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic [LRUBITS-1:0]      LRU_in,
    input  logic [$clog2(WAYS)-1:0] Way,
    output logic [$clog2(WAYS)-1:0] LRU,
    output logic [LRUBITS-1:0]      LRU_out
);

    localparam int c_WW = $clog2(WAYS);

    logic [1:0]         w_cnt0, w_cnt1, w_cnt2, w_cnt3;
    logic [c_WW-1:0]    w_victim;
    logic [1:0]         w_best;
    logic [LRUBITS-1:0] w_next;
    logic [c_WW-1:0]    r_lru;
    logic [LRUBITS-1:0] r_lru_out;

    // Count, per way, how many other ways are more recent than it.
    always_comb begin
        w_cnt0 = 2'({1'b0, ~LRU_in[0]} + {1'b0, ~LRU_in[1]} + {1'b0, ~LRU_in[2]});
        w_cnt1 = 2'({1'b0,  LRU_in[0]} + {1'b0, ~LRU_in[3]} + {1'b0, ~LRU_in[4]});
        w_cnt2 = 2'({1'b0,  LRU_in[1]} + {1'b0,  LRU_in[3]} + {1'b0, ~LRU_in[5]});
        w_cnt3 = 2'({1'b0,  LRU_in[2]} + {1'b0,  LRU_in[4]} + {1'b0,  LRU_in[5]});
    end

    // Strict greater-than keeps the lowest index on ties from cyclic states.
    always_comb begin
        w_victim = 2'd0;
        w_best   = w_cnt0;
        if (w_cnt1 > w_best) begin
            w_victim = 2'd1;
            w_best   = w_cnt1;
        end
        if (w_cnt2 > w_best) begin
            w_victim = 2'd2;
            w_best   = w_cnt2;
        end
        if (w_cnt3 > w_best) begin
            w_victim = 2'd3;
            w_best   = w_cnt3;
        end
    end

    always_comb begin
        w_next = LRU_in;
        case (Way)
            2'd0: begin
                w_next[0] = 1'b1;
                w_next[1] = 1'b1;
                w_next[2] = 1'b1;
            end
            2'd1: begin
                w_next[0] = 1'b0;
                w_next[3] = 1'b1;
                w_next[4] = 1'b1;
            end
            2'd2: begin
                w_next[1] = 1'b0;
                w_next[3] = 1'b0;
                w_next[5] = 1'b1;
            end
            default: begin
                w_next[2] = 1'b0;
                w_next[4] = 1'b0;
                w_next[5] = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lru     <= '0;
            r_lru_out <= '0;
        end else if (go) begin
            r_lru     <= w_victim;
            r_lru_out <= w_next;
        end
    end

    assign LRU     = r_lru;
    assign LRU_out = r_lru_out;

endmodule
`default_nettype wire

// File: tb/tb_lru_bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_lru_bits
// Purpose  : Scoreboard bench for lru_bits against a pairwise-order model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lru_bits;

    logic       clk;
    logic       reset;
    logic       go;
    logic [5:0] LRU_in;
    logic [1:0] Way;
    logic [1:0] LRU;
    logic [5:0] LRU_out;

    int         n_cmp;
    int         n_bad;
    logic [7:0] r_exp_q[$];
    logic [7:0] r_held;

    lru_bits #(.WAYS(4), .LRUBITS(6)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .LRU_in  (LRU_in),
        .Way     (Way),
        .LRU     (LRU),
        .LRU_out (LRU_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got LRU=%0d LRU_out=%b, expected LRU=%0d LRU_out=%b",
                     tag, obs[7:6], obs[5:0], exp[7:6], exp[5:0]);
        end
    endtask

    // Older-than counts per way, derived from the pair table.
    function automatic void model_counts(input logic [5:0] s, output int cnt[4]);
        int pa[6];
        int pb[6];
        pa = '{0, 0, 0, 1, 1, 2};
        pb = '{1, 2, 3, 2, 3, 3};
        for (int w = 0; w < 4; w++) cnt[w] = 0;
        for (int k = 0; k < 6; k++) begin
            if (s[k]) cnt[pb[k]]++;
            else      cnt[pa[k]]++;
        end
    endfunction

    function automatic logic [1:0] model_victim(input logic [5:0] s);
        int cnt[4];
        int best;
        logic [1:0] v;
        model_counts(s, cnt);
        best = -1;
        v    = 2'd0;
        for (int w = 0; w < 4; w++) begin
            if (cnt[w] > best) begin
                best = cnt[w];
                v    = 2'(w);
            end
        end
        return v;
    endfunction

    function automatic logic [5:0] model_update(input logic [5:0] s, input logic [1:0] w);
        int pa[6];
        int pb[6];
        logic [5:0] r;
        pa = '{0, 0, 0, 1, 1, 2};
        pb = '{1, 2, 3, 2, 3, 3};
        r  = s;
        for (int k = 0; k < 6; k++) begin
            if (pa[k] == int'(w)) r[k] = 1'b1;
            if (pb[k] == int'(w)) r[k] = 1'b0;
        end
        return r;
    endfunction

    function automatic bit model_consistent(input logic [5:0] s);
        int cnt[4];
        bit seen[4];
        model_counts(s, cnt);
        for (int w = 0; w < 4; w++) seen[w] = 1'b0;
        for (int w = 0; w < 4; w++) seen[cnt[w]] = 1'b1;
        return seen[0] && seen[1] && seen[2] && seen[3];
    endfunction

    // Drive one cycle, push the expected result, then compare after the edge.
    task automatic step(input string tag, input logic rst_v, input logic go_v,
                        input logic [5:0] s, input logic [1:0] w);
        logic [7:0] exp;
        @(negedge clk);
        reset  = rst_v;
        go     = go_v;
        LRU_in = s;
        Way    = w;
        if (rst_v)     r_held = 8'h00;
        else if (go_v) r_held = {model_victim(s), model_update(s, w)};
        r_exp_q.push_back(r_held);
        @(posedge clk);
        #1;
        exp = r_exp_q.pop_front();
        check_val(tag, {LRU, LRU_out}, exp);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        r_held = 8'h00;
        reset  = 1'b1;
        go     = 1'b0;
        LRU_in = 6'h00;
        Way    = 2'd0;

        step("reset_beats_go", 1'b1, 1'b1, 6'h3F, 2'd2);
        step("way0_from_zero", 1'b0, 1'b1, 6'b000000, 2'd0);
        check_val("way0_literal", {LRU, LRU_out}, {2'd0, 6'b000111});
        step("seq_way1", 1'b0, 1'b1, 6'b000111, 2'd1);
        check_val("seq_way1_literal", {LRU, LRU_out}, {2'd1, 6'b011110});
        step("seq_way2", 1'b0, 1'b1, 6'b011110, 2'd2);
        check_val("seq_way2_literal", {LRU, LRU_out}, {2'd2, 6'b110100});
        step("seq_way3", 1'b0, 1'b1, 6'b110100, 2'd3);
        check_val("seq_way3_literal", {LRU, LRU_out}, {2'd3, 6'b000000});

        step("load_before_hold", 1'b0, 1'b1, 6'b101101, 2'd1);
        for (int i = 0; i < 5; i++)
            step("hold_go0", 1'b0, 1'b0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));

        step("cyclic_tie", 1'b0, 1'b1, 6'b001001, 2'd3);
        check_val("cyclic_literal", {LRU, LRU_out}, {2'd0, 6'b001001});

        step("reset_mid_run", 1'b1, 1'b0, 6'h15, 2'd1);

        for (int s = 0; s < 64; s++) begin
            for (int w = 0; w < 4; w++) begin
                step("exhaustive", 1'b0, 1'b1, 6'(s), 2'(w));
                if (model_consistent(6'(s)) && (2'(w) == model_victim(6'(s))))
                    check_val("promote_victim_moves",
                              {7'd0, model_victim(LRU_out) != LRU}, 8'd1);
            end
        end

        step("final_reset", 1'b1, 1'b1, 6'h2A, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
